// File: rtl/srl_fifo_pkg.sv
// Shared definitions for the SRL-backed first-word-fall-through FIFO.
// Holds the width helper and the occupancy-state enum.
package srl_fifo_pkg;

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

    function automatic occ_state_e occ_state(input int unsigned count, input int unsigned depth);
        if (count == 0) begin
            return EMPTY;
        end
        if (count >= depth) begin
            return FULL;
        end
        return PARTIAL;
    endfunction

endpackage

// File: rtl/srl_fifo_shiftreg.sv
// Addressable shift register.
// A write shifts every slot up by one and loads din into slot 0; the read is combinational.
module srl_fifo_shiftreg #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    // One slot per address so that every addr value selects real storage.
    localparam int unsigned Slots = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [Slots];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[0] <= din;
            for (int i = 1; i < Slots; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/srl_fifo_ctrl.sv
// First-word-fall-through FIFO built around the SRL.
// Tracks occupancy, the registered full/empty flags and the read address of the head entry.
module srl_fifo_ctrl
    import srl_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned ADDR_WIDTH = (DEPTH > 1) ? clog2(DEPTH) : 1,
    parameter int unsigned CNT_WIDTH  = clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [CNT_WIDTH-1:0]  if_num_data
);

    localparam logic [CNT_WIDTH-1:0]  CntOne  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CntFull = CNT_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  empty_n_q, empty_n_d;
    logic                  full_n_q, full_n_d;
    logic                  push, pop;

    assign push = if_write & full_n_q;
    assign pop  = if_read & empty_n_q;

    // rd_addr always tracks max(count-1, 0): the head sits at index count-1 of the SRL.
    always_comb begin
        count_d   = count_q;
        rd_addr_d = rd_addr_q;
        if (push && !pop) begin
            count_d = count_q + CntOne;
            if (count_q != '0) begin
                rd_addr_d = rd_addr_q + AddrOne;
            end
        end else if (pop && !push) begin
            count_d = count_q - CntOne;
            if (count_q != CntOne) begin
                rd_addr_d = rd_addr_q - AddrOne;
            end
        end
        empty_n_d = (count_d != '0);
        full_n_d  = (count_d != CntFull);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            rd_addr_q <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
        end else begin
            count_q   <= count_d;
            rd_addr_q <= rd_addr_d;
            empty_n_q <= empty_n_d;
            full_n_q  <= full_n_d;
        end
    end

    srl_fifo_shiftreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_srl (
        .clk  (clk),
        .we   (push),
        .addr (rd_addr_q),
        .din  (if_din),
        .dout (if_dout)
    );

    assign if_full_n   = full_n_q;
    assign if_empty_n  = empty_n_q;
    assign if_num_data = count_q;

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Bench for srl_fifo_ctrl: DEPTH=2, DEPTH=1 and DEPTH=16 builds against queue models,
// with directed literal checks followed by randomized push/pop traffic.
module tb_srl_fifo_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // DEPTH=2 instance
    logic       wa, ra, fa, ea;
    logic [7:0] da, douta;
    logic [1:0] numa;
    // DEPTH=1 instance
    logic       wb, rb, fb, eb;
    logic [7:0] db, doutb;
    logic [0:0] numb;
    // DEPTH=16 instance
    logic       wc, rc, fc, ec;
    logic [7:0] dc, doutc;
    logic [4:0] numc;

    srl_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(2), .ADDR_WIDTH(1), .CNT_WIDTH(2)) u_a (
        .clk(clk), .reset_n(reset_n), .if_write(wa), .if_din(da), .if_full_n(fa),
        .if_read(ra), .if_dout(douta), .if_empty_n(ea), .if_num_data(numa)
    );

    srl_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(1), .ADDR_WIDTH(1), .CNT_WIDTH(1)) u_b (
        .clk(clk), .reset_n(reset_n), .if_write(wb), .if_din(db), .if_full_n(fb),
        .if_read(rb), .if_dout(doutb), .if_empty_n(eb), .if_num_data(numb)
    );

    srl_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4), .CNT_WIDTH(5)) u_c (
        .clk(clk), .reset_n(reset_n), .if_write(wc), .if_din(dc), .if_full_n(fc),
        .if_read(rc), .if_dout(doutc), .if_empty_n(ec), .if_num_data(numc)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit run   = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    // Reference queues: a request is accepted only if the FIFO had room / data before the edge.
    logic [7:0] qa[$], qb[$], qc[$];
    int sa, sb, sc;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) qa.delete();
        else begin
            sa = qa.size();
            if (ra && sa > 0) void'(qa.pop_front());
            if (wa && sa < 2) qa.push_back(da);
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) qb.delete();
        else begin
            sb = qb.size();
            if (rb && sb > 0) void'(qb.pop_front());
            if (wb && sb < 1) qb.push_back(db);
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) qc.delete();
        else begin
            sc = qc.size();
            if (rc && sc > 0) void'(qc.pop_front());
            if (wc && sc < 16) qc.push_back(dc);
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("a_empty_n", 32'(ea), 32'(qa.size() != 0));
            chk("a_full_n", 32'(fa), 32'(qa.size() != 2));
            chk("a_num", 32'(numa), 32'(qa.size()));
            chk("a_rd_addr", 32'(u_a.rd_addr_q), (qa.size() == 0) ? 32'd0 : 32'(qa.size() - 1));
            if (qa.size() != 0) chk("a_dout", 32'(douta), 32'(qa[0]));

            chk("b_empty_n", 32'(eb), 32'(qb.size() != 0));
            chk("b_full_n", 32'(fb), 32'(qb.size() != 1));
            chk("b_num", 32'(numb), 32'(qb.size()));
            chk("b_rd_addr", 32'(u_b.rd_addr_q), 32'd0);
            if (qb.size() != 0) chk("b_dout", 32'(doutb), 32'(qb[0]));

            chk("c_empty_n", 32'(ec), 32'(qc.size() != 0));
            chk("c_full_n", 32'(fc), 32'(qc.size() != 16));
            chk("c_num", 32'(numc), 32'(qc.size()));
            chk("c_rd_addr", 32'(u_c.rd_addr_q), (qc.size() == 0) ? 32'd0 : 32'(qc.size() - 1));
            if (qc.size() != 0) chk("c_dout", 32'(doutc), 32'(qc[0]));
        end
    end

    initial begin
        wa = 0; ra = 0; da = '0;
        wb = 0; rb = 0; db = '0;
        wc = 0; rc = 0; dc = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        run = 1;
        chk("rst_empty_n", 32'(ea), 32'd0);
        chk("rst_full_n", 32'(fa), 32'd1);
        chk("rst_num", 32'(numa), 32'd0);
        chk("rst_rd_addr", 32'(u_a.rd_addr_q), 32'd0);
        reset_n = 1'b1;

        // Two consecutive pushes, then drain.
        wa = 1; da = 8'hA1;
        @(negedge clk);
        chk("t1_first_vis", 32'(ea), 32'd1);
        chk("t1_first_dout", 32'(douta), 32'hA1);
        da = 8'hB2;
        @(negedge clk);
        wa = 0;
        chk("t1_full_n", 32'(fa), 32'd0);
        chk("t1_num", 32'(numa), 32'd2);
        chk("t1_head", 32'(douta), 32'hA1);
        ra = 1;
        @(negedge clk);
        chk("t1_second", 32'(douta), 32'hB2);
        @(negedge clk);
        ra = 0;
        chk("t1_empty", 32'(ea), 32'd0);
        chk("t1_rd_addr", 32'(u_a.rd_addr_q), 32'd0);

        // Writes against a full FIFO are dropped.
        wa = 1; da = 8'h11;
        @(negedge clk);
        da = 8'h22;
        @(negedge clk);
        da = 8'h33;
        repeat (3) @(negedge clk);
        wa = 0;
        chk("t2_num", 32'(numa), 32'd2);
        chk("t2_head", 32'(douta), 32'h11);
        ra = 1;
        @(negedge clk);
        chk("t2_second", 32'(douta), 32'h22);
        @(negedge clk);
        ra = 0;
        chk("t2_empty", 32'(ea), 32'd0);

        // Simultaneous push and pop at count=1, then a bubble-free stream.
        wa = 1; da = 8'h44;
        @(negedge clk);
        da = 8'h55; ra = 1;
        @(negedge clk);
        chk("t3_num", 32'(numa), 32'd1);
        chk("t3_dout", 32'(douta), 32'h55);
        chk("t3_empty_n", 32'(ea), 32'd1);
        chk("t3_full_n", 32'(fa), 32'd1);
        for (int i = 0; i < 8; i++) begin
            da = 8'(8'h56 + i);
            @(negedge clk);
            chk("t3_stream", 32'(douta), 32'(8'h56 + i));
            chk("t3_stream_num", 32'(numa), 32'd1);
        end
        wa = 0;
        @(negedge clk);
        ra = 0;
        chk("t3_drained", 32'(ea), 32'd0);

        // Read and write while empty: only the push lands.
        wa = 1; ra = 1; da = 8'h66;
        @(negedge clk);
        wa = 0; ra = 0;
        chk("t4_empty_n", 32'(ea), 32'd1);
        chk("t4_dout", 32'(douta), 32'h66);
        chk("t4_num", 32'(numa), 32'd1);
        ra = 1;
        @(negedge clk);
        ra = 0;

        // Asynchronous reset mid-cycle with two entries stored.
        wa = 1; da = 8'h70;
        @(negedge clk);
        da = 8'h71;
        @(negedge clk);
        wa = 0;
        chk("t5_num_pre", 32'(numa), 32'd2);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_async_empty_n", 32'(ea), 32'd0);
        chk("t5_async_full_n", 32'(fa), 32'd1);
        chk("t5_async_num", 32'(numa), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wa = 1; da = 8'h77;
        @(negedge clk);
        wa = 0;
        chk("t5_dout", 32'(douta), 32'h77);
        chk("t5_num", 32'(numa), 32'd1);
        ra = 1;
        @(negedge clk);
        ra = 0;

        // DEPTH=1: alternating push and pop.
        for (int k = 1; k <= 8; k++) begin
            wb = 1; db = 8'(k);
            @(negedge clk);
            wb = 0;
            chk("t6_full_n", 32'(fb), 32'd0);
            chk("t6_empty_n", 32'(eb), 32'd1);
            chk("t6_dout", 32'(doutb), 32'(k));
            rb = 1;
            @(negedge clk);
            rb = 0;
            chk("t6_empty_after", 32'(eb), 32'd0);
            chk("t6_full_after", 32'(fb), 32'd1);
        end
        // Both requests held: flags must alternate every cycle.
        wb = 1; rb = 1;
        for (int k = 0; k < 8; k++) begin
            db = 8'(8'h80 + k);
            @(negedge clk);
            chk("t6_toggle", 32'(eb), 32'(k % 2 == 0));
        end
        wb = 0; rb = 0;
        @(negedge clk);

        // Randomized traffic on all builds with alternating write-heavy / read-heavy phases.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            bit ph_a, ph_c;
            ph_a = ((cyc / 300) % 2) == 0;
            ph_c = ((cyc / 1000) % 2) == 0;
            wa = ($urandom_range(3) < (ph_a ? 3 : 1));
            ra = ($urandom_range(3) < (ph_a ? 1 : 3));
            da = 8'($urandom);
            wb = $urandom_range(1) == 1;
            rb = $urandom_range(1) == 1;
            db = 8'($urandom);
            wc = ($urandom_range(3) < (ph_c ? 3 : 1));
            rc = ($urandom_range(3) < (ph_c ? 1 : 3));
            dc = 8'($urandom);
            @(negedge clk);
        end
        wa = 0; ra = 0; wb = 0; rb = 0; wc = 0; rc = 0;
        @(negedge clk);
        run = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
